line_pid_ctrl: RTL and testbench

Parametrised line-following PID controller that replaces the fixed 4-sensor, 2-bit-error prototype. Each accepted sample frame is thresholded into one bit per sensor, the bits are reduced to a signed weighted position error, and a PID step runs with a clamped integrator and a true derivative. The block then saturates left/right duty values and drives two PWM outputs from one shared counter. It sits between the ADC/SPI front end (producer of `sensor_data`) and the motor driver pins.

---
 rtl/line_pid_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_line_pid_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/line_pid_ctrl.sv
// Line-following PID controller: thresholds a sensor frame into a weighted
// position error, runs a clamped-integrator PID step and drives two PWM pins.
module line_pid_ctrl #(
  parameter int N_SENS   = 4,
  parameter int ADC_W    = 12,
  parameter int PWM_W    = 8,
  parameter int GAIN_W   = 8,
  parameter int SHIFT    = 2,
  parameter int INT_LIM  = 1000,
  parameter int LOST_ERR = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [N_SENS*ADC_W-1:0]   sensor_data,
  input  logic [ADC_W-1:0]          threshold,
  input  logic [GAIN_W-1:0]         kp,
  input  logic [GAIN_W-1:0]         ki,
  input  logic [GAIN_W-1:0]         kd,
  input  logic [PWM_W-1:0]          base_speed,
  output logic [N_SENS-1:0]         sens_bits,
  output logic                      line_lost,
  output logic [PWM_W-1:0]          duty_l,
  output logic [PWM_W-1:0]          duty_r,
  output logic                      duty_valid,
  output logic                      pwm_l,
  output logic                      pwm_r
);

  localparam int E_W   = 8;
  localparam int I_W   = 16;
  localparam int D_W   = E_W + 1;
  localparam int SUM_W = GAIN_W + 1 + I_W + 2;

  localparam logic signed [I_W:0]   LIM_P    = (I_W+1)'(INT_LIM);
  localparam logic signed [I_W:0]   LIM_N    = -LIM_P;
  localparam logic signed [E_W-1:0] LOST_P   = E_W'(LOST_ERR);
  localparam logic signed [SUM_W:0] DUTY_MAX = (SUM_W+1)'(2**PWM_W - 1);

  typedef enum logic [1:0] {IDLE, ERR, PID, OUT} state_t;
  state_t state;

  function automatic logic signed [I_W-1:0] sat_int(input logic signed [I_W:0] v);
    if (v > LIM_P)      sat_int = LIM_P[I_W-1:0];
    else if (v < LIM_N) sat_int = LIM_N[I_W-1:0];
    else                sat_int = v[I_W-1:0];
  endfunction

  function automatic logic [PWM_W-1:0] sat_duty(input logic signed [SUM_W:0] v);
    if (v < 0)             sat_duty = '0;
    else if (v > DUTY_MAX) sat_duty = '1;
    else                   sat_duty = v[PWM_W-1:0];
  endfunction

  // ---- p0: frame capture on accept ----
  logic [N_SENS*ADC_W-1:0] frame_p0;
  logic [ADC_W-1:0]        thr_p0;

  always_ff @(posedge clk) begin
    if (sample_valid && sample_ready) begin
      frame_p0 <= sensor_data;
      thr_p0   <= threshold;
    end
  end

  // ---- p1: threshold and weighted error ----
  logic [N_SENS-1:0]       bits_c;
  logic                    lost_c;
  logic signed [E_W-1:0]   err_c;
  logic signed [E_W-1:0]   err_p1;
  logic signed [E_W-1:0]   prev_err;
  int                      acc;

  always_comb begin
    bits_c = '0;
    acc    = 0;
    for (int i = 0; i < N_SENS; i++) begin
      bits_c[i] = frame_p0[i*ADC_W +: ADC_W] > thr_p0;
      if (bits_c[i]) acc += 2*i - (N_SENS-1);
    end
    lost_c = (bits_c == '0);
    // Lost line keeps steering toward the side the line was last seen on
    if (lost_c) err_c = prev_err[E_W-1] ? -LOST_P : LOST_P;
    else        err_c = E_W'(acc);
  end

  // ---- p2: integrator, derivative, weighted sum ----
  logic signed [I_W-1:0]   integ;
  logic signed [I_W:0]     int_sum;
  logic signed [I_W-1:0]   int_new;
  logic signed [D_W-1:0]   d_c;
  logic signed [SUM_W-1:0] kp_w, ki_w, kd_w, e_w, i_w, d_w, sum_c, delta_c;
  logic signed [SUM_W-1:0] delta_p2;
  logic [PWM_W-1:0]        base_p2;
  logic signed [SUM_W:0]   dsum_l, dsum_r;

  always_comb begin
    int_sum = {integ[I_W-1], integ} + {{(I_W+1-E_W){err_p1[E_W-1]}}, err_p1};
    int_new = (err_p1 == '0 && !line_lost) ? '0 : sat_int(int_sum);
    d_c     = {err_p1[E_W-1], err_p1} - {prev_err[E_W-1], prev_err};
    kp_w    = {{(SUM_W-GAIN_W){1'b0}}, kp};
    ki_w    = {{(SUM_W-GAIN_W){1'b0}}, ki};
    kd_w    = {{(SUM_W-GAIN_W){1'b0}}, kd};
    e_w     = {{(SUM_W-E_W){err_p1[E_W-1]}}, err_p1};
    i_w     = {{(SUM_W-I_W){int_new[I_W-1]}}, int_new};
    d_w     = {{(SUM_W-D_W){d_c[D_W-1]}}, d_c};
    sum_c   = kp_w*e_w + ki_w*i_w + kd_w*d_w;
    delta_c = sum_c >>> SHIFT;
    dsum_l  = {{(SUM_W+1-PWM_W){1'b0}}, base_p2} + {delta_p2[SUM_W-1], delta_p2};
    dsum_r  = {{(SUM_W+1-PWM_W){1'b0}}, base_p2} - {delta_p2[SUM_W-1], delta_p2};
  end

  // ---- control FSM and stage registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sample_ready <= 1'b1;
      duty_valid   <= 1'b0;
      sens_bits    <= '0;
      line_lost    <= 1'b0;
      err_p1       <= '0;
      prev_err     <= '0;
      integ        <= '0;
      delta_p2     <= '0;
      base_p2      <= '0;
      duty_l       <= '0;
      duty_r       <= '0;
    end else begin
      duty_valid <= 1'b0;
      unique case (state)
        IDLE: if (sample_valid) begin
          sample_ready <= 1'b0;
          state        <= ERR;
        end
        ERR: begin
          sens_bits <= bits_c;
          line_lost <= lost_c;
          err_p1    <= err_c;
          state     <= PID;
        end
        PID: begin
          integ    <= int_new;
          prev_err <= err_p1;
          delta_p2 <= delta_c;
          base_p2  <= base_speed;
          state    <= OUT;
        end
        OUT: begin
          duty_l       <= sat_duty(dsum_l);
          duty_r       <= sat_duty(dsum_r);
          duty_valid   <= 1'b1;
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  // ---- PWM: shared counter, duties shadow-loaded on wrap ----
  logic [PWM_W-1:0] cnt, act_l, act_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      act_l <= '0;
      act_r <= '0;
    end else begin
      cnt <= cnt + PWM_W'(1);
      if (cnt == '1) begin
        act_l <= duty_l;
        act_r <= duty_r;
      end
    end
  end

  assign pwm_l = (cnt < act_l);
  assign pwm_r = (cnt < act_r);

endmodule

// File: tb/tb_line_pid_ctrl.sv
// Directed bench for line_pid_ctrl: table of frames with hand-computed duties,
// plus sequences for ignored samples, mid-step reset and PWM shadowing.
module tb_line_pid_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic        sample_ready;
  logic [47:0] sensor_data;
  logic [11:0] threshold;
  logic [7:0]  kp, ki, kd, base_speed;
  logic [3:0]  sens_bits;
  logic        line_lost;
  logic [7:0]  duty_l, duty_r;
  logic        duty_valid;
  logic        pwm_l, pwm_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  line_pid_ctrl #(
    .N_SENS(4), .ADC_W(12), .PWM_W(8), .GAIN_W(8),
    .SHIFT(2), .INT_LIM(10), .LOST_ERR(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sensor_data(sensor_data), .threshold(threshold),
    .kp(kp), .ki(ki), .kd(kd), .base_speed(base_speed),
    .sens_bits(sens_bits), .line_lost(line_lost),
    .duty_l(duty_l), .duty_r(duty_r), .duty_valid(duty_valid),
    .pwm_l(pwm_l), .pwm_r(pwm_r)
  );

  typedef struct {
    bit          do_rst;
    logic [47:0] data;
    logic [11:0] thr;
    logic [7:0]  kp, ki, kd, base;
    logic [3:0]  bits;
    bit          lost;
    logic [7:0]  dl, dr;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [47:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [11:0] a, b, c, d;
    a = c0[11:0]; b = c1[11:0]; c = c2[11:0]; d = c3[11:0];
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(input bit r, input logic [47:0] d, input int g_p, input int g_i,
                              input int g_d, input int bs, input logic [3:0] b, input bit l,
                              input int dl, input int dr);
    vec_t v;
    v.do_rst = r;   v.data = d;       v.thr  = 12'd2048;
    v.kp = g_p[7:0]; v.ki = g_i[7:0]; v.kd = g_d[7:0]; v.base = bs[7:0];
    v.bits = b;     v.lost = l;       v.dl = dl[7:0];  v.dr = dr[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.do_rst) do_reset();
    sensor_data = v.data; threshold = v.thr;
    kp = v.kp; ki = v.ki; kd = v.kd; base_speed = v.base;
    chk({tag, ".ready_idle"}, 32'(sample_ready), 1);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk({tag, ".ready_err"}, 32'(sample_ready), 0);
    @(posedge clk); #1;
    chk({tag, ".bits"}, 32'(sens_bits), 32'(v.bits));
    chk({tag, ".lost"}, 32'(line_lost), 32'(v.lost));
    chk({tag, ".ready_pid"}, 32'(sample_ready), 0);
    @(posedge clk); #1;
    chk({tag, ".dv_early"}, 32'(duty_valid), 0);
    @(posedge clk); #1;
    chk({tag, ".dv"}, 32'(duty_valid), 1);
    chk({tag, ".duty_l"}, 32'(duty_l), 32'(v.dl));
    chk({tag, ".duty_r"}, 32'(duty_r), 32'(v.dr));
    chk({tag, ".ready_back"}, 32'(sample_ready), 1);
    @(posedge clk); #1;
    chk({tag, ".dv_end"}, 32'(duty_valid), 0);
  endtask

  initial begin
    logic [47:0] fa, fc, fz, fn, fb;
    vec_t v;
    int cnt, run;

    fa = pack4(100, 100, 3000, 3000);   // e = +4
    fc = pack4(100, 3000, 3000, 100);   // e = 0
    fz = pack4(0, 0, 0, 0);             // lost
    fn = pack4(3000, 3000, 100, 100);   // e = -4
    fb = pack4(2049, 2048, 0, 0);       // strict compare: only ch0, e = -3

    vecs[0]  = mk(1, fa, 4,   0, 0, 128, 4'b1100, 0, 132, 124);
    vecs[1]  = mk(1, fa, 255, 0, 0, 128, 4'b1100, 0, 255, 0);
    vecs[2]  = mk(1, fa, 0,   1, 0, 128, 4'b1100, 0, 129, 127);
    vecs[3]  = mk(0, fa, 0,   1, 0, 128, 4'b1100, 0, 130, 126);
    vecs[4]  = mk(0, fa, 0,   1, 0, 128, 4'b1100, 0, 130, 126);
    vecs[5]  = mk(0, fa, 0,   1, 0, 128, 4'b1100, 0, 130, 126);
    vecs[6]  = mk(0, fc, 0,   1, 0, 128, 4'b0110, 0, 128, 128);
    vecs[7]  = mk(1, fa, 0,   0, 4, 128, 4'b1100, 0, 132, 124);
    vecs[8]  = mk(0, fa, 0,   0, 4, 128, 4'b1100, 0, 128, 128);
    vecs[9]  = mk(0, fz, 4,   0, 0, 128, 4'b0000, 1, 134, 122);
    vecs[10] = mk(0, fn, 4,   0, 0, 128, 4'b0011, 0, 124, 132);
    vecs[11] = mk(0, fb, 4,   0, 0, 128, 4'b0001, 0, 125, 131);
    vecs[12] = mk(0, fz, 4,   0, 0, 128, 4'b0000, 1, 122, 134);

    rst_n = 1'b0; sample_valid = 1'b0; sensor_data = '0; threshold = '0;
    kp = '0; ki = '0; kd = '0; base_speed = '0;
    #12;
    chk("rst.ready", 32'(sample_ready), 1);
    chk("rst.dv", 32'(duty_valid), 0);
    chk("rst.duty_l", 32'(duty_l), 0);
    chk("rst.duty_r", 32'(duty_r), 0);
    chk("rst.bits", 32'(sens_bits), 0);
    chk("rst.lost", 32'(line_lost), 0);
    chk("rst.pwm", 32'({pwm_l, pwm_r}), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Frame offered during ERR must be dropped
    do_reset();
    sensor_data = fa; threshold = 12'd2048; kp = 8'd4; ki = '0; kd = '0; base_speed = 8'd128;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    chk("ign.ready_err", 32'(sample_ready), 0);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ign.dv", 32'(duty_valid), 1);
    chk("ign.duty_l", 32'(duty_l), 132);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (duty_valid) cnt++;
    end
    chk("ign.extra_pulses", 32'(cnt), 0);

    // Reset while in PID aborts the step
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid.ready", 32'(sample_ready), 1);
    chk("mid.duty_l", 32'(duty_l), 0);
    chk("mid.duty_r", 32'(duty_r), 0);
    chk("mid.bits", 32'(sens_bits), 0);
    chk("mid.dv", 32'(duty_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (duty_valid) cnt++;
    end
    chk("mid.no_pulse", 32'(cnt), 0);

    // PWM: duty 64 written mid-period only shows after the wrap
    v = mk(1, fa, 0, 0, 0, 64, 4'b1100, 0, 64, 64);
    run_vec(v, "pwm64");
    cnt = 0;
    while (!pwm_l && cnt < 300) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("pwm64.low_before_wrap", 32'(cnt > 200 && cnt < 300), 1);
    run = 0;
    while (pwm_l && run < 300) begin
      run++;
      @(posedge clk); #1;
    end
    chk("pwm64.high_run", 32'(run), 64);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_l) cnt++;
      @(posedge clk); #1;
    end
    chk("pwm64.high_per_period", 32'(cnt), 64);

    // Duty 0: constant low once the shadow has reloaded
    v = mk(0, fa, 0, 0, 0, 0, 4'b1100, 0, 0, 0);
    run_vec(v, "pwm0");
    repeat (260) @(posedge clk);
    #1;
    cnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (pwm_l || pwm_r) cnt++;
      @(posedge clk); #1;
    end
    chk("pwm0.high_count", 32'(cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
